// File: rtl/ex_stage_pipe.sv
// ---------------------------------------------------------------------------
// ex_stage_pipe
//
// Execute-stage pipeline register. It holds one instruction entry between
// decode and memory and uses a valid/ready handshake on both sides. For each
// entry it:
//   - registers the ALU/CSR result, which is also the memory address;
//   - checks load/store alignment and merges the result with any upstream
//     exception;
//   - issues exactly one request to the selected multi-cycle functional unit
//     before the entry may leave.
//
// Optional feature: define EX_STALL_CNT_EN to build a 32-bit FU stall
// counter. When the macro is not defined, stall_cnt is tied to zero.
//
// Ports:
//   clk, rst_n                  clock; synchronous active-low reset
//   in_valid / in_ready         upstream handshake
//   out_valid / out_ready       downstream handshake
//   flush                       kills the held entry (ex/ertn)
//   pc_in/out, result_in/out    instruction PC and ALU/CSR result
//   payload_in/out              opaque sideband, carried unchanged
//   fu_sel_in                   one-hot FU selector (zero = no FU)
//   mem_acc_in, mem_size_in     load/store flag and size (0=B 1=H 2=W)
//   fu_req_valid/ready          per-channel FU request handshake
//   exc_in, ecode_in,
//   esubcode_in                 upstream exception
//   next_exc                    a later stage is excepting or doing ertn
//   this_exc                    held entry is excepting or blocked
//   exc_out, ecode_out,
//   esubcode_out, badv_out      registered exception info
//   stall_cnt                   FU stall cycle counter
// ---------------------------------------------------------------------------
module ex_stage_pipe #(
    parameter int                DATA_W    = 32,
    parameter int                PAYLOAD_W = 64,
    parameter int                NUM_FU    = 2,
    parameter logic [5:0]        ECODE_ALE = 6'h9,
    parameter logic [DATA_W-1:0] RESET_PC  = DATA_W'(32'h1c000000)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 flush,
    input  logic [DATA_W-1:0]    pc_in,
    output logic [DATA_W-1:0]    pc_out,
    input  logic [DATA_W-1:0]    result_in,
    output logic [DATA_W-1:0]    result_out,
    input  logic [PAYLOAD_W-1:0] payload_in,
    output logic [PAYLOAD_W-1:0] payload_out,
    input  logic [NUM_FU-1:0]    fu_sel_in,
    input  logic                 mem_acc_in,
    input  logic [1:0]           mem_size_in,
    output logic [NUM_FU-1:0]    fu_req_valid,
    input  logic [NUM_FU-1:0]    fu_req_ready,
    input  logic                 exc_in,
    input  logic [5:0]           ecode_in,
    input  logic [8:0]           esubcode_in,
    input  logic                 next_exc,
    output logic                 this_exc,
    output logic                 exc_out,
    output logic [5:0]           ecode_out,
    output logic [8:0]           esubcode_out,
    output logic [DATA_W-1:0]    badv_out,
    output logic [31:0]          stall_cnt
);

    logic              v_r;
    logic              issued_r;
    logic [NUM_FU-1:0] fu_sel_r;

    logic in_fire_s;
    logic out_fire_s;
    logic need_fu_s;
    logic fu_fire_s;
    logic ready_go_s;
    logic ale_s;

    // Alignment rule: a halfword needs bit 0 clear, a word needs bits [1:0]
    // clear, and a byte is always aligned.
    function automatic logic addr_misaligned(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
        logic mis;
        case (size)
            2'd1:    mis = addr_lo[0];
            2'd2:    mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Handshake, FU request and exception flags for the held entry.
    always_comb begin
        this_exc  = v_r && (exc_out || next_exc);
        need_fu_s = (|fu_sel_r) && !issued_r;
        // Requests are suppressed by an exception, by a flush, and by reset.
        // This keeps a request from firing on an entry that is about to die.
        fu_req_valid = (rst_n && v_r && !issued_r && !this_exc && !flush)
                       ? fu_sel_r : {NUM_FU{1'b0}};
        fu_fire_s  = |(fu_req_valid & fu_req_ready);
        ready_go_s = !v_r || flush || this_exc || !need_fu_s || fu_fire_s;
        out_valid  = rst_n && v_r && ready_go_s && !flush;
        in_ready   = rst_n && (!v_r || (ready_go_s && out_ready) || flush);
        in_fire_s  = in_valid && in_ready;
        out_fire_s = out_valid && out_ready;
        ale_s      = mem_acc_in && addr_misaligned(mem_size_in, result_in[1:0]);
    end

    // Entry occupancy and the one-shot issued flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_r      <= 1'b0;
            issued_r <= 1'b0;
        end else if (in_fire_s) begin
            // A new entry wins over flush and out_fire in the same cycle.
            v_r      <= 1'b1;
            issued_r <= 1'b0;
        end else if (out_fire_s || flush) begin
            v_r      <= 1'b0;
            issued_r <= 1'b0;
        end else if (fu_fire_s) begin
            issued_r <= 1'b1;
        end
    end

    // Entry data and exception registers; they load only on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_out       <= RESET_PC;
            result_out   <= {DATA_W{1'b0}};
            payload_out  <= {PAYLOAD_W{1'b0}};
            fu_sel_r     <= {NUM_FU{1'b0}};
            exc_out      <= 1'b0;
            ecode_out    <= 6'h0;
            esubcode_out <= 9'h0;
            badv_out     <= {DATA_W{1'b0}};
        end else if (in_fire_s) begin
            pc_out       <= pc_in;
            result_out   <= result_in;
            payload_out  <= payload_in;
            fu_sel_r     <= fu_sel_in;
            exc_out      <= exc_in | ale_s;
            // An upstream exception takes priority over misalignment.
            ecode_out    <= exc_in ? ecode_in : (ale_s ? ECODE_ALE : 6'h0);
            esubcode_out <= exc_in ? esubcode_in : 9'h0;
            badv_out     <= result_in;
        end
    end

`ifdef EX_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Counts cycles spent waiting on an FU request. The counter wraps and
    // is deliberately not cleared by flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'h0;
        end else if (v_r && need_fu_s && !ready_go_s) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ex_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_ex_stage_pipe
//
// Directed bench for ex_stage_pipe, using the default parameters. Inputs
// change 1 ns after each rising edge. Outputs are checked 1 ns after the
// inputs settle, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_ex_stage_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        flush;
    logic [31:0] pc_in;
    logic [31:0] pc_out;
    logic [31:0] result_in;
    logic [31:0] result_out;
    logic [63:0] payload_in;
    logic [63:0] payload_out;
    logic [1:0]  fu_sel_in;
    logic        mem_acc_in;
    logic [1:0]  mem_size_in;
    logic [1:0]  fu_req_valid;
    logic [1:0]  fu_req_ready;
    logic        exc_in;
    logic [5:0]  ecode_in;
    logic [8:0]  esubcode_in;
    logic        next_exc;
    logic        this_exc;
    logic        exc_out;
    logic [5:0]  ecode_out;
    logic [8:0]  esubcode_out;
    logic [31:0] badv_out;
    logic [31:0] stall_cnt;

    int checks;
    int errors;
    int hi_cnt;
    int fire_cnt;
    logic [31:0] exp_stall;

    ex_stage_pipe dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .flush        (flush),
        .pc_in        (pc_in),
        .pc_out       (pc_out),
        .result_in    (result_in),
        .result_out   (result_out),
        .payload_in   (payload_in),
        .payload_out  (payload_out),
        .fu_sel_in    (fu_sel_in),
        .mem_acc_in   (mem_acc_in),
        .mem_size_in  (mem_size_in),
        .fu_req_valid (fu_req_valid),
        .fu_req_ready (fu_req_ready),
        .exc_in       (exc_in),
        .ecode_in     (ecode_in),
        .esubcode_in  (esubcode_in),
        .next_exc     (next_exc),
        .this_exc     (this_exc),
        .exc_out      (exc_out),
        .ecode_out    (ecode_out),
        .esubcode_out (esubcode_out),
        .badv_out     (badv_out),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Tally FU request cycles and handshakes on channel 1.
    task automatic sample_fu();
        if (fu_req_valid == 2'b10) hi_cnt++;
        if ((fu_req_valid & fu_req_ready) != 2'b00) fire_cnt++;
    endtask

    initial begin
        checks = 0; errors = 0; hi_cnt = 0; fire_cnt = 0;
`ifdef EX_STALL_CNT_EN
        exp_stall = 32'd4;
`else
        exp_stall = 32'd0;
`endif
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        pc_in = 32'h0; result_in = 32'h0; payload_in = 64'h0; fu_sel_in = 2'b00;
        mem_acc_in = 1'b0; mem_size_in = 2'd0; fu_req_ready = 2'b00;
        exc_in = 1'b0; ecode_in = 6'h0; esubcode_in = 9'h0; next_exc = 1'b0;

        // ---- reset state ----
        tick(); tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_fu_req", 64'(fu_req_valid), 64'd0);
        chk("rst_pc_out", 64'(pc_out), 64'h1c000000);
        chk("rst_result_out", 64'(result_out), 64'd0);
        chk("rst_exc_out", 64'(exc_out), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        rst_n = 1'b1; #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // ---- three back-to-back entries, no FU ----
        in_valid = 1'b1; out_ready = 1'b1; pc_in = 32'h1c000000;
        result_in = 32'h11; payload_in = 64'hdeadbeef01234567; #1;
        chk("b2b_in_ready0", 64'(in_ready), 64'd1);
        tick(); pc_in = 32'h1c000004; payload_in = 64'h1; #1;
        chk("b2b_out_valid0", 64'(out_valid), 64'd1);
        chk("b2b_pc0", 64'(pc_out), 64'h1c000000);
        chk("b2b_result0", 64'(result_out), 64'h11);
        chk("b2b_payload0", payload_out, 64'hdeadbeef01234567);
        chk("b2b_in_ready1", 64'(in_ready), 64'd1);
        tick(); pc_in = 32'h1c000008; #1;
        chk("b2b_out_valid1", 64'(out_valid), 64'd1);
        chk("b2b_pc1", 64'(pc_out), 64'h1c000004);
        chk("b2b_in_ready2", 64'(in_ready), 64'd1);
        tick(); in_valid = 1'b0; #1;
        chk("b2b_out_valid2", 64'(out_valid), 64'd1);
        chk("b2b_pc2", 64'(pc_out), 64'h1c000008);
        tick();
        chk("b2b_drained", 64'(out_valid), 64'd0);

        // ---- FU channel 1, ready low for 4 cycles ----
        in_valid = 1'b1; pc_in = 32'h1c00000c; fu_sel_in = 2'b10; fu_req_ready = 2'b00;
        tick(); in_valid = 1'b0; fu_sel_in = 2'b00; #1;
        chk("fu_in_ready_busy", 64'(in_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            sample_fu();
            chk("fu_wait_out_valid", 64'(out_valid), 64'd0);
            tick();
        end
        fu_req_ready = 2'b10; #1;
        sample_fu();
        chk("fu_fire_out_valid", 64'(out_valid), 64'd1);
        chk("fu_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        tick(); fu_req_ready = 2'b00; #1;
        sample_fu();
        chk("fu_after_req", 64'(fu_req_valid), 64'd0);
        chk("fu_after_out_valid", 64'(out_valid), 64'd0);
        chk("fu_req_cycles", 64'(hi_cnt), 64'd5);
        chk("fu_fires", 64'(fire_cnt), 64'd1);

        // ---- alignment and exception merge ----
        in_valid = 1'b1; mem_acc_in = 1'b1; mem_size_in = 2'd2;
        result_in = 32'h10000002; fu_sel_in = 2'b01;
        tick(); mem_size_in = 2'd1; result_in = 32'h3; fu_sel_in = 2'b00; #1;
        chk("ale_w_exc", 64'(exc_out), 64'd1);
        chk("ale_w_ecode", 64'(ecode_out), 64'h9);
        chk("ale_w_esub", 64'(esubcode_out), 64'h0);
        chk("ale_w_badv", 64'(badv_out), 64'h10000002);
        chk("ale_w_this_exc", 64'(this_exc), 64'd1);
        chk("ale_w_no_req", 64'(fu_req_valid), 64'd0);
        chk("ale_w_out_valid", 64'(out_valid), 64'd1);
        tick(); result_in = 32'h2; exc_in = 1'b1; ecode_in = 6'h3; esubcode_in = 9'h5; #1;
        chk("ale_h_exc", 64'(exc_out), 64'd1);
        chk("ale_h_ecode", 64'(ecode_out), 64'h9);
        chk("ale_h_badv", 64'(badv_out), 64'h3);
        tick(); mem_size_in = 2'd0; result_in = 32'h3; exc_in = 1'b0;
        ecode_in = 6'h0; esubcode_in = 9'h0; #1;
        chk("exc_in_exc", 64'(exc_out), 64'd1);
        chk("exc_in_ecode", 64'(ecode_out), 64'h3);
        chk("exc_in_esub", 64'(esubcode_out), 64'h5);
        tick(); in_valid = 1'b0; mem_acc_in = 1'b0; #1;
        chk("byte_exc", 64'(exc_out), 64'd0);
        chk("byte_ecode", 64'(ecode_out), 64'h0);
        chk("byte_this_exc", 64'(this_exc), 64'd0);
        chk("byte_out_valid", 64'(out_valid), 64'd1);
        tick();
        chk("exc_drained", 64'(out_valid), 64'd0);

        // ---- next_exc suppresses the FU request ----
        in_valid = 1'b1; fu_sel_in = 2'b01; next_exc = 1'b1;
        tick(); in_valid = 1'b0; fu_sel_in = 2'b00; #1;
        chk("nexc_no_req", 64'(fu_req_valid), 64'd0);
        chk("nexc_this_exc", 64'(this_exc), 64'd1);
        chk("nexc_out_valid", 64'(out_valid), 64'd1);
        tick(); next_exc = 1'b0; #1;
        chk("nexc_drained", 64'(out_valid), 64'd0);

        // ---- flush while an FU request is pending ----
        in_valid = 1'b1; fu_sel_in = 2'b01;
        tick(); in_valid = 1'b0; fu_sel_in = 2'b00; #1;
        chk("fl_req_before", 64'(fu_req_valid), 64'h1);
        flush = 1'b1; #1;
        chk("fl_req_drop", 64'(fu_req_valid), 64'd0);
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        tick(); flush = 1'b0; #1;
        chk("fl_empty_req", 64'(fu_req_valid), 64'd0);
        chk("fl_empty_out_valid", 64'(out_valid), 64'd0);
        chk("fl_empty_in_ready", 64'(in_ready), 64'd1);

        // ---- FU fires while downstream stalls ----
        in_valid = 1'b1; fu_sel_in = 2'b01; fu_req_ready = 2'b01; out_ready = 1'b0;
        tick(); in_valid = 1'b0; fu_sel_in = 2'b00; #1;
        chk("ds_req", 64'(fu_req_valid), 64'h1);
        chk("ds_out_valid_fire", 64'(out_valid), 64'd1);
        chk("ds_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ds_no_rereq", 64'(fu_req_valid), 64'd0);
            chk("ds_hold_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1; #1;
        chk("ds_in_ready_go", 64'(in_ready), 64'd1);
        tick(); fu_req_ready = 2'b00; #1;
        chk("ds_left", 64'(out_valid), 64'd0);

        // ---- reset in the middle of an FU wait ----
        in_valid = 1'b1; pc_in = 32'h1c000100; fu_sel_in = 2'b10;
        tick(); in_valid = 1'b0; fu_sel_in = 2'b00; #1;
        chk("rw_req", 64'(fu_req_valid), 64'h2);
        chk("rw_pc", 64'(pc_out), 64'h1c000100);
        rst_n = 1'b0; #1;
        chk("rw_req_in_rst", 64'(fu_req_valid), 64'd0);
        chk("rw_in_ready_in_rst", 64'(in_ready), 64'd0);
        tick(); rst_n = 1'b1; #1;
        chk("rw_req_after", 64'(fu_req_valid), 64'd0);
        chk("rw_pc_after", 64'(pc_out), 64'h1c000000);
        chk("rw_out_valid_after", 64'(out_valid), 64'd0);
        chk("rw_in_ready_after", 64'(in_ready), 64'd1);
        chk("rw_stall_after", 64'(stall_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
